// File: rtl/lsu_ctrl_if.sv
// Pipeline-side and memory-bus-side handshake bundles for the load/store unit.
// All channels are valid/ready: a transfer happens on a rising edge where both are high.

interface lsu_req_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_bus_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   localparam int NBYTES = XLEN / 8;

   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [XLEN-1:0]   bus_wdata;
   logic [NBYTES-1:0] bus_wstrb;
   logic              bus_resp_valid;
   logic [XLEN-1:0]   bus_resp_rdata;
   logic              bus_resp_err;

   modport master (
      output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );

   modport slave (
      input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: aligns store lanes, extracts and extends load lanes,
// rejects misaligned/oversized accesses and bounds the bus response wait.

module lsu_ctrl #(
   parameter int XLEN    = 64,
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   lsu_req_if.slave   pipe,
   lsu_bus_if.master  bus,
   output logic [1:0] state_dbg
);

   localparam int NBYTES = XLEN / 8;
   localparam int OFFW   = $clog2(NBYTES);
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e            state;
   state_e            state_next;
   logic              write_q;
   logic              uns_q;
   logic [1:0]        size_q;
   logic [OFFW-1:0]   off_q;
   logic [CNT_W-1:0]  cnt;
   logic [OFFW-1:0]   off_in;
   logic [OFFW-1:0]   align_mask;
   logic [NBYTES-1:0] strb_base;
   logic              illegal;
   logic [XLEN-1:0]   shifted;
   logic              msb;
   logic [XLEN-1:0]   rdata_ext;
   logic              timeout_hit;

   assign off_in    = pipe.req_addr[OFFW-1:0];
   assign state_dbg = state;

   assign pipe.req_ready    = (state == IDLE);
   assign pipe.resp_valid   = (state == DONE);
   assign bus.bus_req_valid = (state == ISSUE);

   // Request decode: lane strobes and alignment, evaluated on the incoming fields.
   always_comb begin
      align_mask = '0;
      strb_base  = '0;
      for (int i = 0; i < OFFW; i++) align_mask[i] = (i < int'(pipe.req_size));
      for (int i = 0; i < NBYTES; i++) strb_base[i] = (i < (1 << pipe.req_size));
      illegal = (int'(pipe.req_size) > OFFW) || ((off_in & align_mask) != '0);
   end

   // Load extraction: right-justify the addressed lanes, then fill above the field width.
   always_comb begin
      shifted = bus.bus_resp_rdata >> {off_q, 3'b000};
      msb     = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == (8 << size_q) - 1) msb = shifted[i];
      end
      rdata_ext = shifted;
      for (int i = 0; i < XLEN; i++) begin
         if (i >= (8 << size_q)) rdata_ext[i] = uns_q ? 1'b0 : msb;
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pipe.req_valid) state_next = illegal ? DONE : ISSUE;
         ISSUE:   if (bus.bus_req_ready) state_next = WAIT;
         WAIT:    if (bus.bus_resp_valid || timeout_hit) state_next = DONE;
         DONE:    if (pipe.resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_q         <= 1'b0;
         uns_q           <= 1'b0;
         size_q          <= '0;
         off_q           <= '0;
         cnt             <= '0;
         pipe.resp_rdata <= '0;
         pipe.resp_err   <= 1'b0;
         bus.bus_we      <= 1'b0;
         bus.bus_addr    <= '0;
         bus.bus_wdata   <= '0;
         bus.bus_wstrb   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pipe.req_valid) begin
                  write_q <= pipe.req_write;
                  uns_q   <= pipe.req_unsigned;
                  size_q  <= pipe.req_size;
                  off_q   <= off_in;
                  if (illegal) begin
                     pipe.resp_err   <= 1'b1;
                     pipe.resp_rdata <= '0;
                  end else begin
                     bus.bus_addr  <= {pipe.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                     bus.bus_we    <= pipe.req_write;
                     bus.bus_wdata <= pipe.req_wdata << {off_in, 3'b000};
                     bus.bus_wstrb <= pipe.req_write ? (strb_base << off_in) : '0;
                  end
               end
            end
            ISSUE: begin
               if (bus.bus_req_ready) cnt <= '0;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               // A response on the limit cycle takes priority over the timeout.
               if (bus.bus_resp_valid) begin
                  pipe.resp_err   <= bus.bus_resp_err;
                  pipe.resp_rdata <= (write_q || bus.bus_resp_err) ? '0 : rdata_ext;
               end else if (timeout_hit) begin
                  pipe.resp_err   <= 1'b1;
                  pipe.resp_rdata <= '0;
               end
            end
            DONE: begin
               if (pipe.resp_ready) begin
                  pipe.resp_err   <= 1'b0;
                  pipe.resp_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised, multi-cycle load/store access unit between the execute stage and a handshaked data-memory bus.
- Replaces the single-cycle combinational memory stage.
- Adds these functions:
  - valid/ready request and response handshakes;
  - byte-lane alignment of write data and strobes;
  - lane extraction and sign/zero extension of read data;
  - misalignment detection;
  - a bus response timeout.

Parameters:
- XLEN, 64, data width in bits. Legal values are 32 and 64. NBYTES = XLEN/8; OFFW = log2(NBYTES).
- ADDR_W, 64, address width.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error is returned. 0 disables the timeout.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline access request
- req_ready  out  1  unit can accept a request (= state==IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  log2 of access bytes (0=B, 1=H, 2=W, 3=D)
- req_unsigned  in  1  zero-extend load when 1, sign-extend when 0
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, bus error or timeout
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts request
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  req_addr with low OFFW bits cleared
- bus_wdata  out  XLEN  lane-shifted store data
- bus_wstrb  out  NBYTES  byte strobes; all 0 on reads
- bus_resp_valid  in  1  bus response
- bus_resp_rdata  in  XLEN  full-width read word
- bus_resp_err  in  1  bus error

Behaviour:
- Reset (asynchronous):
  - state=IDLE;
  - resp_valid, resp_err, bus_req_valid, bus_we = 0;
  - resp_rdata, bus_addr, bus_wdata, bus_wstrb = 0;
  - timeout counter = 0.
  - No request is accepted while reset is high.
  - Reset mid-transaction aborts it. Any later bus response is ignored.
- States and transitions: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - A request is accepted when req_valid is high (req_ready=1). All request fields are latched.
  - off = req_addr[OFFW-1:0].
  - Illegal when (1<<req_size) > NBYTES, or when off is not a multiple of (1<<req_size).
  - Illegal request: go to DONE with resp_err=1 and resp_rdata=0. No bus activity.
  - Legal request: go to ISSUE.
- ISSUE:
  - bus_req_valid=1, with registered bus_addr/bus_we/bus_wdata/bus_wstrb.
  - bus_wdata = wdata << (8*off).
  - bus_wstrb = ((1<<(1<<size))-1) << off on writes; 0 on reads.
  - Held stable until bus_req_ready=1, then go to WAIT and clear the counter.
  - There is no timeout while in ISSUE.
- WAIT:
  - bus_req_valid=0. The counter increments each cycle.
  - On bus_resp_valid, go to DONE with resp_err = bus_resp_err.
  - For a load without error, resp_rdata = extend((bus_resp_rdata >> 8*off), 8<<size bits, req_unsigned).
  - For a store or an error, resp_rdata = 0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without a response, go to DONE with resp_err=1 and resp_rdata=0.
  - A response arriving in the same cycle as the limit is reached wins.
- DONE:
  - resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1, then go to IDLE.
  - The next request is accepted one cycle later; there is no same-cycle turnaround.
- bus_resp_valid is ignored outside WAIT.
- Latency (req accept edge = cycle 0):
  - Best case, resp_valid is asserted in cycle 3 (bus ready in cycle 1, response in cycle 2).
  - Illegal request: resp_valid in cycle 1.
- Extension:
  - size==log2(NBYTES) passes the word through unchanged.
  - Otherwise the upper bits are filled with the MSB of the extracted field (signed) or 0 (unsigned).

Test Plan:
- XLEN=64. Load byte addr 0x8000_0003, signed, bus_rdata=0x0000_0000_8000_0000 (byte3=0x80) -> bus_addr=0x8000_0000, wstrb=0, resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_err=0, resp_valid in cycle 3.
- Store half addr 0x1006, wdata=0xABCD -> bus_wdata=0xABCD_0000_0000_0000, bus_wstrb=0xC0, bus_we=1, held across 4 cycles of bus_req_ready=0; resp_rdata=0.
- Load word addr 0x1002 -> no bus_req_valid, resp_valid in cycle 1 with resp_err=1; an unsigned load word at 0x1004 with rdata 0xFFFFFFFF_00000000 -> 0x0000_0000_FFFF_FFFF.
- TIMEOUT=4, no bus response -> resp_err=1 after 4 WAIT cycles; a late bus_resp_valid in IDLE has no effect; the next request completes normally.
- Assert reset while in WAIT -> all outputs reach reset values immediately; req_ready=1 after release; a bus response following reset is ignored.
- XLEN=32, req_size=3 -> resp_err=1 with no bus activity; resp_ready held low for 5 cycles keeps resp_valid/resp_err stable.
